vga_layer_scheduler: RTL and testbench

//  Sits between vga_sync and the DAC pins. Shares the single VGA pixel output among
//  N_LAYERS graphics generators (wall, paddle, ball, text...) by fixed priority.

---
 rtl/vga_layer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_vga_layer_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_scheduler.sv
// vga_layer_scheduler
// Shares the single VGA pixel output among N_LAYERS graphics generators by fixed
// priority (layer 0 highest), delays hsync/vsync by one clk so they line up with
// the registered colour, and runs a once-per-frame game-logic update window that
// opens at the first blank line. If the window is still open at the frame wrap,
// the sticky overrun flag is set.
//
// Ports
//   clk, rst                async active-high reset
//   pix_tick                1-clk pixel strobe; frame events are sampled only on it
//   v_on, p_x, p_y          video-on and pixel position from vga_sync
//   hsync_in, vsync_in      raw syncs from vga_sync
//   layer_on, layer_rgb     per-layer request and packed colour (layer i at i*RGB_W)
//   upd_done                game logic finished its update (pulse or level)
//   rgb, grant              registered winning colour and one-hot winner
//   hsync_out, vsync_out    syncs delayed 1 clk
//   upd_start, upd_busy     update window handshake
//   overrun                 sticky: a window closed without upd_done
//   frame_cnt               completed frames
module vga_layer_scheduler #(
  parameter int                 N_LAYERS = 4,
  parameter int                 RGB_W    = 12,
  parameter logic [RGB_W-1:0]   BG_RGB   = 12'h000,
  parameter int                 VD       = 480,
  parameter int                 VMAX     = 524
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_tick,
  input  logic                      v_on,
  input  logic [9:0]                p_x,
  input  logic [9:0]                p_y,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic                      upd_done,
  output logic [RGB_W-1:0]          rgb,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [N_LAYERS-1:0]       grant,
  output logic                      upd_start,
  output logic                      upd_busy,
  output logic                      overrun,
  output logic [15:0]               frame_cnt
);

  localparam logic [9:0] VdLine   = 10'(VD);
  localparam logic [9:0] VmaxLine = 10'(VMAX);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    UPDATE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_r, stateNext_s;
  logic [RGB_W-1:0]   winRgb_s;
  logic [N_LAYERS-1:0] winGrant_s;
  logic               anyOn_s;
  logic               lineTick_s, vblStart_s, frameEnd_s, wrap_s;
  logic               frameEndSeen_r;
  logic               startNext_s, busyNext_s, ovrSet_s;

  // Fixed-priority pick: the first set request, scanning from layer 0, wins.
  always_comb begin
    winRgb_s   = {RGB_W{1'b0}};
    winGrant_s = {N_LAYERS{1'b0}};
    anyOn_s    = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (layer_on[i] && !anyOn_s) begin
        winRgb_s      = layer_rgb[i*RGB_W +: RGB_W];
        winGrant_s[i] = 1'b1;
        anyOn_s       = 1'b1;
      end else begin
        anyOn_s = anyOn_s;
      end
    end
  end

  // Pixel and sync registers: updated every clk so colour and syncs stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= {RGB_W{1'b0}};
      grant     <= {N_LAYERS{1'b0}};
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      if (!v_on) begin
        rgb   <= {RGB_W{1'b0}};
        grant <= {N_LAYERS{1'b0}};
      end else if (anyOn_s) begin
        rgb   <= winRgb_s;
        grant <= winGrant_s;
      end else begin
        rgb   <= BG_RGB;
        grant <= {N_LAYERS{1'b0}};
      end
    end
  end

  // Frame events are only meaningful on the pixel strobe at the start of a line.
  assign lineTick_s = pix_tick && (p_x == 10'd0);
  assign vblStart_s = lineTick_s && (p_y == VdLine);
  assign frameEnd_s = lineTick_s && (p_y == VmaxLine);
  // A wrap only counts once the last line of the frame has actually been seen.
  assign wrap_s     = lineTick_s && (p_y == 10'd0) && frameEndSeen_r;

  // Remembers that the last line was reached, armed until the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameEndSeen_r <= 1'b0;
    end else if (wrap_s) begin
      frameEndSeen_r <= 1'b0;
    end else if (frameEnd_s) begin
      frameEndSeen_r <= 1'b1;
    end else begin
      frameEndSeen_r <= frameEndSeen_r;
    end
  end

  // Update-window next state; done beats a same-clk wrap, so no overrun then.
  always_comb begin
    stateNext_s = state_r;
    startNext_s = 1'b0;
    busyNext_s  = 1'b0;
    ovrSet_s    = 1'b0;
    case (state_r)
      ACTIVE: begin
        if (vblStart_s) begin
          stateNext_s = UPDATE;
          startNext_s = 1'b1;
        end else begin
          stateNext_s = ACTIVE;
        end
      end
      UPDATE: begin
        if (upd_done) begin
          stateNext_s = HOLD;
        end else if (wrap_s) begin
          stateNext_s = ACTIVE;
          ovrSet_s    = 1'b1;
        end else begin
          busyNext_s  = 1'b1;
        end
      end
      HOLD: begin
        if (wrap_s) begin
          stateNext_s = ACTIVE;
        end else begin
          stateNext_s = HOLD;
        end
      end
      default: begin
        stateNext_s = ACTIVE;
      end
    endcase
  end

  // Window state, handshake outputs, sticky overrun and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ACTIVE;
      upd_start <= 1'b0;
      upd_busy  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state_r   <= stateNext_s;
      upd_start <= startNext_s;
      upd_busy  <= busyNext_s;
      overrun   <= overrun | ovrSet_s;
      if (wrap_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_scheduler.sv
module tb_vga_layer_scheduler;

  localparam int          N    = 4;
  localparam int          W    = 12;
  localparam int          VD   = 480;
  localparam int          VMAX = 524;
  localparam logic [11:0] BG   = 12'h5A3;

  logic          clk, rst, pix_tick, v_on, hsync_in, vsync_in, upd_done;
  logic [9:0]    p_x, p_y;
  logic [N-1:0]  layer_on;
  logic [N*W-1:0] layer_rgb;
  logic [W-1:0]  rgb;
  logic          hsync_out, vsync_out, upd_start, upd_busy, overrun;
  logic [N-1:0]  grant;
  logic [15:0]   frame_cnt;

  int vecs, errs;

  // reference model: expected outputs plus frame/window bookkeeping
  logic [11:0] m_rgb;
  logic [3:0]  m_grant;
  logic        m_hs, m_vs, m_start, m_busy, m_ovr;
  logic [15:0] m_fcnt;
  logic        m_win;   // window open, done not yet seen
  logic        m_wait;  // a window was opened this frame; waiting for the wrap
  logic        m_seen;  // last line of the frame has been passed

  vga_layer_scheduler #(.N_LAYERS(N), .RGB_W(W), .BG_RGB(BG), .VD(VD), .VMAX(VMAX)) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .v_on(v_on), .p_x(p_x), .p_y(p_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_on(layer_on), .layer_rgb(layer_rgb),
    .upd_done(upd_done), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .grant(grant), .upd_start(upd_start), .upd_busy(upd_busy), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_rgb = 12'h000; m_grant = 4'b0000; m_hs = 1'b0; m_vs = 1'b0;
    m_start = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_fcnt = 16'd0;
    m_win = 1'b0; m_wait = 1'b0; m_seen = 1'b0;
  endtask

  // Predict the effect of the current inputs, then advance one clock.
  task automatic cycle();
    logic [11:0] r;
    logic [3:0]  g;
    logic        tick0, wrap, vbl, was, st, bz, hs, vs;
    r = 12'h000;
    g = 4'b0000;
    if (v_on) begin
      r = BG;
      for (int i = 0; i < N; i++) begin
        if (layer_on[i]) begin
          r = layer_rgb[i*W +: W];
          g = 4'b0001 << i;
          break;
        end
      end
    end
    tick0 = pix_tick && (p_x == 10'd0);
    wrap  = tick0 && (p_y == 10'd0) && m_seen;
    vbl   = tick0 && (p_y == 10'(VD));
    st    = 1'b0;
    was   = m_win;
    if (m_win) begin
      if (upd_done) begin
        m_win = 1'b0;
      end else if (wrap) begin
        m_win = 1'b0; m_wait = 1'b0; m_ovr = 1'b1;
      end
    end else if (m_wait) begin
      if (wrap) m_wait = 1'b0;
    end else if (vbl) begin
      m_win = 1'b1; m_wait = 1'b1; st = 1'b1;
    end
    bz = was && m_win;
    if (wrap) begin
      m_seen = 1'b0;
      m_fcnt = m_fcnt + 16'd1;
    end else if (tick0 && (p_y == 10'(VMAX))) begin
      m_seen = 1'b1;
    end
    hs = hsync_in;
    vs = vsync_in;
    @(posedge clk);
    #1;
    m_rgb = r; m_grant = g; m_hs = hs; m_vs = vs; m_start = st; m_busy = bz;
  endtask

  // One pixel strobe at the start of line y.
  task automatic tick_line(input int y);
    p_x = 10'd0; p_y = 10'(y); pix_tick = 1'b1;
    cycle();
    pix_tick = 1'b0; p_x = 10'd7;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (rgb !== 12'h000) begin errs++; $display("FAIL reset_rgb got %h want 000", rgb); end
    vecs++; if (frame_cnt !== 16'd0 || overrun !== 1'b0 || upd_busy !== 1'b0 || upd_start !== 1'b0)
      begin errs++; $display("FAIL reset_ctrl got cnt=%h ovr=%b busy=%b start=%b want 0", frame_cnt, overrun, upd_busy, upd_start); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    v_on = 1'b1; layer_on = 4'b0001; layer_rgb[11:0] = 12'hABC; hsync_in = 1'b1;
    cycle();
    vecs++; if (rgb !== 12'hABC) begin errs++; $display("FAIL post_reset_rgb got %h want abc", rgb); end
    vecs++; if (hsync_out !== 1'b1) begin errs++; $display("FAIL post_reset_hsync got %b want 1", hsync_out); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (rgb !== 12'h000 || grant !== 4'b0000 || hsync_out !== 1'b0)
      begin errs++; $display("FAIL midline_reset got rgb=%h grant=%b hs=%b want 0", rgb, grant, hsync_out); end
    model_reset();
    rst = 1'b0;
    cycle();
    vecs++; if (rgb !== 12'hABC || grant !== 4'b0001)
      begin errs++; $display("FAIL release_rgb got %h/%b want abc/0001", rgb, grant); end
  endtask

  task automatic test_priority();
    v_on = 1'b1; layer_on = 4'b0110;
    layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'h111};
    cycle();
    vecs++; if (rgb !== 12'hF00 || grant !== 4'b0010)
      begin errs++; $display("FAIL prio_0110 got %h/%b want f00/0010", rgb, grant); end
    layer_on = 4'b1000;
    cycle();
    vecs++; if (rgb !== 12'h00F || grant !== 4'b1000)
      begin errs++; $display("FAIL prio_1000 got %h/%b want 00f/1000", rgb, grant); end
    for (int k = 0; k < 8; k++) begin
      layer_on = 4'($urandom_range(1, 15));
      layer_rgb = {$urandom, $urandom};
      cycle();
      vecs++; if (rgb !== m_rgb || grant !== m_grant)
        begin errs++; $display("FAIL prio_rand on=%b got %h/%b want %h/%b", layer_on, rgb, grant, m_rgb, m_grant); end
    end
  endtask

  task automatic test_background();
    v_on = 1'b1; layer_on = 4'b0000;
    cycle();
    vecs++; if (rgb !== BG || grant !== 4'b0000)
      begin errs++; $display("FAIL background got %h/%b want %h/0000", rgb, grant, BG); end
    v_on = 1'b0; layer_on = 4'b1111;
    cycle();
    vecs++; if (rgb !== 12'h000 || grant !== 4'b0000)
      begin errs++; $display("FAIL blanked got %h/%b want 000/0000", rgb, grant); end
  endtask

  task automatic test_update_window();
    tick_line(VD);
    vecs++; if (upd_start !== 1'b1 || upd_busy !== 1'b0)
      begin errs++; $display("FAIL win_start got start=%b busy=%b want 1/0", upd_start, upd_busy); end
    cycle();
    vecs++; if (upd_start !== 1'b0 || upd_busy !== 1'b1)
      begin errs++; $display("FAIL win_busy got start=%b busy=%b want 0/1", upd_start, upd_busy); end
    repeat (98) cycle();
    vecs++; if (upd_busy !== 1'b1) begin errs++; $display("FAIL win_hold_busy got %b want 1", upd_busy); end
    upd_done = 1'b1;
    cycle();
    upd_done = 1'b0;
    vecs++; if (upd_busy !== 1'b0 || overrun !== 1'b0)
      begin errs++; $display("FAIL win_done got busy=%b ovr=%b want 0/0", upd_busy, overrun); end
    tick_line(VMAX);
    tick_line(0);
    vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL frame_cnt1 got %0d want 1", frame_cnt); end
  endtask

  task automatic test_overrun();
    tick_line(VD);
    repeat (20) cycle();
    tick_line(VMAX);
    tick_line(0);
    vecs++; if (upd_busy !== 1'b0 || overrun !== 1'b1 || frame_cnt !== 16'd2)
      begin errs++; $display("FAIL overrun got busy=%b ovr=%b cnt=%0d want 0/1/2", upd_busy, overrun, frame_cnt); end
    upd_done = 1'b1;
    cycle();
    upd_done = 1'b0;
    repeat (5) cycle();
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_done_at_wrap();
    tick_line(VD);
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    vecs++; if (upd_busy !== 1'b0 || overrun !== 1'b0 || frame_cnt !== 16'd0)
      begin errs++; $display("FAIL reset_window got busy=%b ovr=%b cnt=%0d want 0", upd_busy, overrun, frame_cnt); end
    model_reset();
    rst = 1'b0;
    tick_line(VD);
    repeat (5) cycle();
    tick_line(VMAX);
    p_x = 10'd0; p_y = 10'd0; pix_tick = 1'b1; upd_done = 1'b1;
    cycle();
    pix_tick = 1'b0; upd_done = 1'b0; p_x = 10'd3;
    vecs++; if (overrun !== 1'b0 || upd_busy !== 1'b0 || frame_cnt !== 16'd1)
      begin errs++; $display("FAIL done_at_wrap got ovr=%b busy=%b cnt=%0d want 0/0/1", overrun, upd_busy, frame_cnt); end
    cycle();
    vecs++; if (overrun !== 1'b0 || upd_busy !== 1'b0)
      begin errs++; $display("FAIL after_done_wrap got ovr=%b busy=%b want 0/0", overrun, upd_busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      v_on = 1'($urandom);
      layer_on = 4'($urandom);
      layer_rgb = {$urandom, $urandom};
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      pix_tick = ($urandom_range(0, 3) == 0);
      p_x = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 799));
      case ($urandom_range(0, 7))
        0: p_y = 10'd0;
        1: p_y = 10'(VD);
        2: p_y = 10'(VMAX);
        default: p_y = 10'($urandom_range(0, VMAX));
      endcase
      upd_done = ($urandom_range(0, 15) == 0);
      cycle();
      vecs++; if (rgb !== m_rgb) begin errs++; $display("FAIL rnd_rgb n=%0d got %h want %h", n, rgb, m_rgb); end
      vecs++; if (grant !== m_grant) begin errs++; $display("FAIL rnd_grant n=%0d got %b want %b", n, grant, m_grant); end
      vecs++; if (hsync_out !== m_hs) begin errs++; $display("FAIL rnd_hsync n=%0d got %b want %b", n, hsync_out, m_hs); end
      vecs++; if (vsync_out !== m_vs) begin errs++; $display("FAIL rnd_vsync n=%0d got %b want %b", n, vsync_out, m_vs); end
      vecs++; if (upd_start !== m_start) begin errs++; $display("FAIL rnd_start n=%0d got %b want %b", n, upd_start, m_start); end
      vecs++; if (upd_busy !== m_busy) begin errs++; $display("FAIL rnd_busy n=%0d got %b want %b", n, upd_busy, m_busy); end
      vecs++; if (overrun !== m_ovr) begin errs++; $display("FAIL rnd_overrun n=%0d got %b want %b", n, overrun, m_ovr); end
      vecs++; if (frame_cnt !== m_fcnt) begin errs++; $display("FAIL rnd_frame_cnt n=%0d got %0d want %0d", n, frame_cnt, m_fcnt); end
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b1; pix_tick = 1'b0; v_on = 1'b0; p_x = 10'd7; p_y = 10'd0;
    hsync_in = 1'b0; vsync_in = 1'b0; layer_on = 4'b0000; layer_rgb = '0; upd_done = 1'b0;
    model_reset();
    test_reset();
    test_priority();
    test_background();
    test_update_window();
    test_overrun();
    test_done_at_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
